// File: rtl/jac1_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : jac1_prog_loader
// Description : Upstream program loader for the JAC1 core. Receives a framed
//               byte stream (count N, 2N data bytes high-byte first, 8-bit
//               checksum), writes each assembled 16-bit word into program
//               memory and keeps the CPU held in reset until a load finishes
//               with a matching checksum.
// Ports       : clk, res           - clock, synchronous active-high reset
//               start              - one-cycle request to begin a load
//               byte_in/byte_valid - incoming stream byte and its qualifier
//               byte_ready         - loader accepts a byte this cycle
//               pm_wr_en/adr/data  - program memory write port
//               cpu_hold           - 1 keeps the CPU in reset
//               done / err         - result of the last load
// Revision    : 1.0 - initial release
// ============================================================================
module jac1_prog_loader #(
  parameter int DataWidth = 8,
  parameter int IRWidth   = 16,
  parameter int PC_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 start,
  input  logic [DataWidth-1:0] byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic                 pm_wr_en,
  output logic [PC_WIDTH-1:0]  pm_wr_adr,
  output logic [IRWidth-1:0]   pm_wr_data,
  output logic                 cpu_hold,
  output logic                 done,
  output logic                 err
);

  // Width wide enough to compare the incremented word index against N.
  localparam int c_CMPW = (DataWidth > PC_WIDTH + 1) ? DataWidth : PC_WIDTH + 1;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_COUNT = 4'd1,
    S_HI    = 4'd2,
    S_LO    = 4'd3,
    S_WRITE = 4'd4,
    S_CHECK = 4'd5,
    S_DONE  = 4'd6,
    S_ERR   = 4'd7
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [DataWidth-1:0] r_count;
  logic [DataWidth-1:0] r_hi;
  logic [DataWidth-1:0] r_sum;
  logic [PC_WIDTH-1:0]  r_idx;

  logic                 r_byte_ready;
  logic                 r_pm_wr_en;
  logic [PC_WIDTH-1:0]  r_pm_wr_adr;
  logic [IRWidth-1:0]   r_pm_wr_data;
  logic                 r_cpu_hold;
  logic                 r_done;
  logic                 r_err;

  logic                 w_xfer;
  logic                 w_last;
  logic [c_CMPW-1:0]    w_idx_inc;
  logic [c_CMPW-1:0]    w_cnt_ext;
  logic                 w_ready_nxt;

  // r_byte_ready always mirrors the current state, so it doubles as the
  // handshake qualifier.
  assign w_xfer    = byte_valid && r_byte_ready;
  assign w_idx_inc = c_CMPW'(r_idx) + c_CMPW'(1);
  assign w_cnt_ext = c_CMPW'(r_count);
  assign w_last    = (w_idx_inc == w_cnt_ext);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (res) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_COUNT;
      end
      S_COUNT: begin
        if (w_xfer) begin
          w_state_nxt = (byte_in == '0) ? S_ERR : S_HI;
        end
      end
      S_HI: begin
        if (w_xfer) w_state_nxt = S_LO;
      end
      S_LO: begin
        if (w_xfer) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        w_state_nxt = w_last ? S_CHECK : S_HI;
      end
      S_CHECK: begin
        if (w_xfer) begin
          w_state_nxt = (byte_in == r_sum) ? S_DONE : S_ERR;
        end
      end
      S_DONE, S_ERR: begin
        if (start) w_state_nxt = S_COUNT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_ready_nxt = (w_state_nxt == S_COUNT) || (w_state_nxt == S_HI) ||
                       (w_state_nxt == S_LO)    || (w_state_nxt == S_CHECK);

  // --------------------------------------------------------------------------
  // Registered outputs and datapath. Outputs are decoded from the next state
  // so they line up with the state they describe without a combinational
  // path to the ports.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (res) begin
      r_byte_ready <= 1'b0;
      r_pm_wr_en   <= 1'b0;
      r_pm_wr_adr  <= '0;
      r_pm_wr_data <= '0;
      r_cpu_hold   <= 1'b1;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_count      <= '0;
      r_hi         <= '0;
      r_sum        <= '0;
      r_idx        <= '0;
    end else begin
      r_byte_ready <= w_ready_nxt;
      r_pm_wr_en   <= (w_state_nxt == S_WRITE);
      r_done       <= (w_state_nxt == S_DONE);
      r_err        <= (w_state_nxt == S_ERR);
      r_cpu_hold   <= (w_state_nxt != S_DONE);

      case (r_state)
        S_COUNT: begin
          if (w_xfer) begin
            r_count <= byte_in;
            r_idx   <= '0;
            r_sum   <= '0;
          end
        end
        S_HI: begin
          if (w_xfer) begin
            r_hi  <= byte_in;
            r_sum <= r_sum + byte_in;
          end
        end
        S_LO: begin
          // Address/data are loaded on the way into WRITE and then simply
          // held until the next word.
          if (w_xfer) begin
            r_sum        <= r_sum + byte_in;
            r_pm_wr_adr  <= r_idx;
            r_pm_wr_data <= IRWidth'({r_hi, byte_in});
          end
        end
        S_WRITE: begin
          r_idx <= r_idx + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign byte_ready = r_byte_ready;
  assign pm_wr_en   = r_pm_wr_en;
  assign pm_wr_adr  = r_pm_wr_adr;
  assign pm_wr_data = r_pm_wr_data;
  assign cpu_hold   = r_cpu_hold;
  assign done       = r_done;
  assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_jac1_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_jac1_prog_loader
// Description : Directed self-checking bench for jac1_prog_loader. A negedge
//               monitor logs every program memory write; the main sequence
//               drives frames and compares against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jac1_prog_loader;

  logic        clk;
  logic        res;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        pm_wr_en;
  logic [7:0]  pm_wr_adr;
  logic [15:0] pm_wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;
  int base;

  // Write log filled by the monitor.
  logic [7:0]  mon_adr  [0:31];
  logic [15:0] mon_data [0:31];
  logic        mon_rdy  [0:31];
  logic        mon_rep  [0:31];
  int          mon_n = 0;
  logic        mon_prev = 1'b0;

  jac1_prog_loader #(
    .DataWidth (8),
    .IRWidth   (16),
    .PC_WIDTH  (8)
  ) dut (
    .clk        (clk),
    .res        (res),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .pm_wr_en   (pm_wr_en),
    .pm_wr_adr  (pm_wr_adr),
    .pm_wr_data (pm_wr_data),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pm_wr_en === 1'b1 && mon_n < 32) begin
      mon_adr[mon_n]  = pm_wr_adr;
      mon_data[mon_n] = pm_wr_data;
      mon_rdy[mon_n]  = byte_ready;
      mon_rep[mon_n]  = mon_prev;
      mon_n           = mon_n + 1;
    end
    mon_prev = (pm_wr_en === 1'b1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Present one byte and hold it until it is accepted (bounded wait).
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clk);
    while (byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", {31'd0, byte_ready}, 32'd1);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic chk_write(input string tag, input int i, input logic [7:0] adr,
                           input logic [15:0] data);
    if (i < 32) begin
      chk({tag, "_adr"},   {24'd0, mon_adr[i]},  {24'd0, adr});
      chk({tag, "_data"},  {16'd0, mon_data[i]}, {16'd0, data});
      chk({tag, "_ready"}, {31'd0, mon_rdy[i]},  32'd0);
      chk({tag, "_pulse"}, {31'd0, mon_rep[i]},  32'd0);
    end else begin
      chk({tag, "_index"}, i, 32'd0);
    end
  endtask

  initial begin
    res        = 1'b1;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    res = 1'b0;

    // Reset state after 5 idle cycles
    idle(5);
    chk("rst_hold",  {31'd0, cpu_hold},   32'd1);
    chk("rst_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_done",  {31'd0, done},       32'd0);
    chk("rst_err",   {31'd0, err},        32'd0);
    chk("rst_wr_en", {31'd0, pm_wr_en},   32'd0);
    chk("rst_adr",   {24'd0, pm_wr_adr},  32'd0);
    chk("rst_data",  {16'd0, pm_wr_data}, 32'd0);

    // Good 2-word frame
    base = mon_n;
    pulse_start();
    chk("a_ready_after_start", {31'd0, byte_ready}, 32'd1);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(8'hBE);
    chk("a_done",   {31'd0, done},       32'd1);
    chk("a_err",    {31'd0, err},        32'd0);
    chk("a_hold",   {31'd0, cpu_hold},   32'd0);
    chk("a_ready",  {31'd0, byte_ready}, 32'd0);
    chk("a_nwr",    mon_n - base,        32'd2);
    chk_write("a_w0", base,     8'h00, 16'h1234);
    chk_write("a_w1", base + 1, 8'h01, 16'hABCD);
    chk("a_adr_hold",  {24'd0, pm_wr_adr},  32'h01);
    chk("a_data_hold", {16'd0, pm_wr_data}, 32'hABCD);

    // Same frame, bad checksum
    base = mon_n;
    pulse_start();
    chk("b_done_clr", {31'd0, done},     32'd0);
    chk("b_hold_set", {31'd0, cpu_hold}, 32'd1);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(8'hBF);
    chk("b_err",  {31'd0, err},      32'd1);
    chk("b_done", {31'd0, done},     32'd0);
    chk("b_hold", {31'd0, cpu_hold}, 32'd1);
    chk("b_nwr",  mon_n - base,      32'd2);
    chk_write("b_w0", base,     8'h00, 16'h1234);
    chk_write("b_w1", base + 1, 8'h01, 16'hABCD);

    // Count byte zero
    base = mon_n;
    pulse_start();
    chk("c_err_clr", {31'd0, err}, 32'd0);
    send_byte(8'h00);
    chk("c_err",   {31'd0, err},        32'd1);
    chk("c_hold",  {31'd0, cpu_hold},   32'd1);
    chk("c_ready", {31'd0, byte_ready}, 32'd0);
    idle(3);
    chk("c_nwr",   mon_n - base,        32'd0);

    // Gapped stream with an ignored mid-frame start
    base = mon_n;
    pulse_start();
    idle($urandom_range(0, 3));
    send_byte(8'h02);
    idle($urandom_range(0, 3));
    send_byte(8'h12);
    pulse_start();
    idle($urandom_range(0, 3));
    send_byte(8'h34);
    idle($urandom_range(0, 3));
    send_byte(8'hAB);
    idle($urandom_range(0, 3));
    send_byte(8'hCD);
    idle($urandom_range(0, 3));
    send_byte(8'hBE);
    chk("d_done", {31'd0, done},     32'd1);
    chk("d_err",  {31'd0, err},      32'd0);
    chk("d_hold", {31'd0, cpu_hold}, 32'd0);
    chk("d_nwr",  mon_n - base,      32'd2);
    chk_write("d_w0", base,     8'h00, 16'h1234);
    chk_write("d_w1", base + 1, 8'h01, 16'hABCD);

    // Reset mid-frame, then a 1-word load
    base = mon_n;
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    idle(1);
    chk("e_nwr_pre", mon_n - base, 32'd1);
    res = 1'b1;
    @(posedge clk);
    #1;
    res = 1'b0;
    chk("e_hold",  {31'd0, cpu_hold},   32'd1);
    chk("e_ready", {31'd0, byte_ready}, 32'd0);
    chk("e_done",  {31'd0, done},       32'd0);
    chk("e_wr_en", {31'd0, pm_wr_en},   32'd0);
    chk("e_data",  {16'd0, pm_wr_data}, 32'd0);
    idle(2);
    chk("e_idle_ready", {31'd0, byte_ready}, 32'd0);
    base = mon_n;
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'hFF);
    chk("f_done", {31'd0, done},     32'd1);
    chk("f_hold", {31'd0, cpu_hold}, 32'd0);
    chk("f_nwr",  mon_n - base,      32'd1);
    chk_write("f_w0", base, 8'h00, 16'h00FF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
